pio_gen2: RTL



---
 rtl/pio_gen2_pkg.sv | 17 +
 rtl/pio_gen2_sync.sv | 31 +++
 rtl/pio_gen2.sv | 127 ++++++++++++
 3 files changed

// File: rtl/pio_gen2_pkg.sv
// pio_gen2_pkg
// Shared constants for the pio_gen2 GPIO peripheral: Avalon register
// indices and the encodings accepted by the EDGE_TYPE parameter.
package pio_gen2_pkg;

  localparam logic [2:0] ADDR_DATA    = 3'd0;
  localparam logic [2:0] ADDR_DIR     = 3'd1;
  localparam logic [2:0] ADDR_IRQMASK = 3'd2;
  localparam logic [2:0] ADDR_EDGECAP = 3'd3;
  localparam logic [2:0] ADDR_OUTSET  = 3'd4;
  localparam logic [2:0] ADDR_OUTCLR  = 3'd5;

  localparam int EDGE_RISE = 0;
  localparam int EDGE_FALL = 1;
  localparam int EDGE_ANY  = 2;

endpackage

// File: rtl/pio_gen2_sync.sv
// pio_gen2_sync
// WIDTH-wide multi-flop synchroniser for asynchronous pad inputs.
// Ports:
//   clk    - system clock
//   reset  - synchronous active-high reset, clears every stage
//   d      - asynchronous input bits
//   q      - synchronised output (last stage of the chain)
module pio_gen2_sync #(
  parameter int WIDTH  = 16,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] stage [STAGES];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < STAGES; i++) stage[i] <= '0;
    end else begin
      stage[0] <= d;
      for (int i = 1; i < STAGES; i++) stage[i] <= stage[i-1];
    end
  end

  assign q = stage[STAGES-1];

endmodule

// File: rtl/pio_gen2.sv
// pio_gen2
// Parametrised GPIO peripheral on an Avalon-MM slave (read latency 1):
// per-bit direction, synchronised inputs, atomic set/clear of the output
// register, edge capture and a maskable level interrupt.
// Ports:
//   clk, reset         - system clock, synchronous active-high reset
//   address            - register index (see pio_gen2_pkg)
//   chipselect/write_n - write strobe qualifiers (write = cs && !write_n)
//   writedata          - write data, bits above WIDTH ignored
//   readdata           - registered read data, zero-extended
//   in_port            - asynchronous pad inputs
//   out_port, out_oe   - output data register and direction register
//   irq                - registered level interrupt
module pio_gen2 #(
  parameter int          WIDTH       = 16,
  parameter int          SYNC_STAGES = 2,
  parameter int          EDGE_TYPE   = 0,
  parameter logic [31:0] OUT_RESET   = 32'h0,
  parameter logic [31:0] DIR_RESET   = 32'h0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic [WIDTH-1:0] out_port,
  output logic [WIDTH-1:0] out_oe,
  output logic             irq
);
  import pio_gen2_pkg::*;

  localparam int ARM_W = $clog2(SYNC_STAGES + 2);
  localparam logic [ARM_W-1:0] ARM_LOAD = ARM_W'(SYNC_STAGES + 1);

  logic [WIDTH-1:0] data_out;
  logic [WIDTH-1:0] dir;
  logic [WIDTH-1:0] irqmask;
  logic [WIDTH-1:0] edgecap;
  logic [WIDTH-1:0] sync_in;
  logic [WIDTH-1:0] prev_in;
  logic [WIDTH-1:0] edge_raw;
  logic [WIDTH-1:0] edge_ev;
  logic [WIDTH-1:0] cap_clr;
  logic [WIDTH-1:0] wd;
  logic [WIDTH-1:0] rd_val;
  logic [ARM_W-1:0] arm_cnt;
  logic             wr_en;
  logic             unused_wd;

  assign wr_en     = chipselect && !write_n;
  assign wd        = writedata[WIDTH-1:0];
  assign unused_wd = ^writedata;

  pio_gen2_sync #(
    .WIDTH  (WIDTH),
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (in_port),
    .q     (sync_in)
  );

  always_comb begin
    edge_raw = '0;
    case (EDGE_TYPE)
      EDGE_RISE: edge_raw = sync_in & ~prev_in;
      EDGE_FALL: edge_raw = ~sync_in & prev_in;
      default:   edge_raw = sync_in ^ prev_in;
    endcase
  end

  // Synchroniser stages are flushed to 0 by reset, so a pad already high
  // would look like a fresh edge once it propagates; hold off capture
  // until the chain and prev_in carry real pad history.
  assign edge_ev = (arm_cnt == '0) ? edge_raw : '0;

  assign cap_clr = (wr_en && address == ADDR_EDGECAP) ? wd : '0;

  always_comb begin
    rd_val = '0;
    case (address)
      ADDR_DATA:    rd_val = (dir & data_out) | (~dir & sync_in);
      ADDR_DIR:     rd_val = dir;
      ADDR_IRQMASK: rd_val = irqmask;
      ADDR_EDGECAP: rd_val = edgecap;
      default:      rd_val = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      data_out <= OUT_RESET[WIDTH-1:0];
      dir      <= DIR_RESET[WIDTH-1:0];
      irqmask  <= '0;
      edgecap  <= '0;
      prev_in  <= '0;
      arm_cnt  <= ARM_LOAD;
      irq      <= 1'b0;
      readdata <= '0;
    end else begin
      if (arm_cnt != '0) arm_cnt <= arm_cnt - ARM_W'(1);
      prev_in <= sync_in;
      if (wr_en) begin
        case (address)
          ADDR_DATA:    data_out <= wd;
          ADDR_DIR:     dir      <= wd;
          ADDR_IRQMASK: irqmask  <= wd;
          ADDR_OUTSET:  data_out <= data_out | wd;
          ADDR_OUTCLR:  data_out <= data_out & ~wd;
          default:      ;
        endcase
      end
      // New events are OR-ed in after the clear so a coincident event wins.
      edgecap  <= (edgecap & ~cap_clr) | edge_ev;
      irq      <= |(edgecap & irqmask);
      readdata <= 32'(rd_val);
    end
  end

  assign out_port = data_out;
  assign out_oe   = dir;

endmodule
